// File: rtl/imem_loader.sv
// imem_loader: write side of the instruction memory.
// Receives a byte stream over valid/ready. The stream carries, in order:
//   - a 32-bit little-endian word count N,
//   - N program words,
//   - a 32-bit XOR checksum C.
// Program words go to consecutive inst_mem word addresses from 0. When C
// matches, cpu_run releases the core.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   start              1-cycle pulse that begins a load session
//   in_byte/in_valid   stream byte and its valid
//   in_ready           loader accepts a byte this cycle (HEADER/LOAD/CHECK)
//   mem_we/mem_addr/mem_wdata  inst_mem write port (1-cycle pulse per word)
//   cpu_run            program loaded and verified
//   busy               session in progress
//   error/err_code     sticky failure flag; 1 = bad length, 2 = checksum mismatch
//   words_loaded       words written this session
module imem_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned WL_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx;
    logic [23:0]       word_q;     // previously accepted bytes of the current word
    logic [31:0]       csum;
    logic [WL_W-1:0]   len_q;
    logic [1:0]        err_code_d;

    logic              accept;
    logic              last_byte;
    logic [31:0]       word_asm;   // word completed by the byte on in_byte
    logic              len_ok;
    logic              clear;
    logic              wr_word;

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code;
        clear      = 1'b0;
        wr_word    = 1'b0;
        accept     = in_valid && in_ready;
        last_byte  = accept && (byte_idx == 2'd3);
        // The newest byte lands in [31:24]; earlier bytes have shifted down.
        word_asm   = {in_byte, word_q};
        len_ok     = (word_asm != 32'd0) && (word_asm <= 32'(DEPTH));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HEADER;
                    clear      = 1'b1;
                    err_code_d = 2'd0;
                end
            end
            S_HEADER: begin
                if (last_byte) begin
                    if (len_ok) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d    = S_ERROR;
                        err_code_d = 2'd1;
                    end
                end
            end
            S_LOAD: begin
                if (last_byte) begin
                    wr_word = 1'b1;
                    if ((words_loaded + WL_W'(1)) == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (last_byte) begin
                    if (word_asm == csum) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERROR;
                        err_code_d = 2'd2;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_HEADER;
                    clear      = 1'b1;
                    err_code_d = 2'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_idx     <= 2'd0;
            word_q       <= 24'd0;
            csum         <= 32'd0;
            len_q        <= '0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'd0;
            words_loaded <= '0;
        end else begin
            state_q  <= state_d;
            err_code <= err_code_d;
            in_ready <= (state_d == S_HEADER) || (state_d == S_LOAD) || (state_d == S_CHECK);
            busy     <= (state_d == S_HEADER) || (state_d == S_LOAD) || (state_d == S_CHECK);
            cpu_run  <= (state_d == S_DONE);
            error    <= (state_d == S_ERROR);
            mem_we   <= 1'b0;

            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                word_q   <= word_asm[31:8];
            end

            if ((state_q == S_HEADER) && last_byte && len_ok) begin
                len_q <= word_asm[WL_W-1:0];
            end

            // Write lands one cycle after the 4th byte; mem_addr holds afterwards.
            if (wr_word) begin
                mem_we       <= 1'b1;
                mem_addr     <= words_loaded[ADDR_W-1:0];
                mem_wdata    <= word_asm;
                words_loaded <= words_loaded + WL_W'(1);
                csum         <= csum ^ word_asm;
            end

            if (clear) begin
                byte_idx     <= 2'd0;
                csum         <= 32'd0;
                words_loaded <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random load sessions,
// compared against an expectation built from the stream contents.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        in_byte = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              error;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_loaded;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog [DEPTH];
    logic [ADDR_W-1:0] wr_a [$];
    logic [31:0]       wr_d [$];

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every inst_mem write.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte after 'gap' idle cycles and hold it until it is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gmode);
        for (int b = 0; b < 4; b++) begin
            int gap;
            gap = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
            send_byte(w[8*b +: 8], gap);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full session; gmode 0 = back-to-back, 1 = valid toggles, 2 = random gaps.
    task automatic run_load(input logic [31:0] n, input logic [31:0] c,
                            input int gmode, input bit poke);
        bit          legal;
        bit          ok;
        int          nw;
        logic [31:0] cs;
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_cpu_run", 64'(cpu_run), 64'd0);
        check("start_error", 64'({error, err_code}), 64'd0);
        check("start_words", 64'(words_loaded), 64'd0);

        send_word(n, gmode);
        legal = (n >= 32'd1) && (n <= 32'(DEPTH));
        if (legal) begin
            for (int i = 0; i < int'(n); i++) begin
                send_word(prog[i], gmode);
                if (poke && i == 0) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    pulse_start();
                end
            end
            send_word(c, gmode);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Expectation from the stream contents.
        nw = legal ? int'(n) : 0;
        cs = 32'd0;
        for (int i = 0; i < nw; i++) cs ^= prog[i];
        ok = legal && (c == cs);

        check("n_writes", 64'(wr_a.size()), 64'(nw));
        for (int i = 0; i < nw && i < wr_a.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), 64'(wr_a[i]), 64'(i));
            check($sformatf("wr_data[%0d]", i), 64'(wr_d[i]), 64'(prog[i]));
        end
        check("words_loaded", 64'(words_loaded), 64'(nw));
        check("cpu_run", 64'(cpu_run), 64'(ok));
        check("error", 64'(error), 64'(!ok));
        check("err_code", 64'(err_code), !legal ? 64'd1 : ok ? 64'd0 : 64'd2);
        check("busy_end", 64'(busy), 64'd0);
        check("in_ready_end", 64'(in_ready), 64'd0);
    endtask

    function automatic logic [31:0] xor_prog(input int n);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < n; i++) s ^= prog[i];
        return s;
    endfunction

    initial begin
        // Reset and idle behaviour.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_flags", 64'({cpu_run, busy, error, err_code}), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;

        // Nominal two-word load.
        prog[0] = 32'h8C010004;
        prog[1] = 32'h00221820;
        run_load(32'd2, 32'h8C231824, 0, 1'b0);

        // Bad checksum.
        run_load(32'd2, 32'h00000000, 0, 1'b0);

        // Bad lengths, including one whose low bits look legal.
        run_load(32'd0, 32'd0, 0, 1'b0);
        run_load(32'd65, 32'd0, 0, 1'b0);
        run_load(32'h00000101, 32'd0, 0, 1'b0);

        // Full-depth load.
        for (int i = 0; i < int'(DEPTH); i++) prog[i] = $urandom;
        run_load(32'(DEPTH), xor_prog(DEPTH), 2, 1'b0);

        // Backpressure with a stray start mid-LOAD.
        prog[0] = 32'h8C010004;
        prog[1] = 32'h00221820;
        run_load(32'd2, 32'h8C231824, 1, 1'b1);

        // Random sessions, some with a corrupted checksum.
        for (int t = 0; t < 4; t++) begin
            int n;
            logic [31:0] c;
            n = int'($urandom_range(1, 10));
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            c = xor_prog(n);
            if ($urandom_range(0, 1) == 1) c ^= (32'd1 << $urandom_range(0, 31));
            run_load(32'(n), c, 2, 1'b0);
        end

        // Reset after 6 LOAD bytes of a 2-word session.
        prog[0] = 32'h8C010004;
        prog[1] = 32'h00221820;
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        send_word(32'd2, 0);
        send_word(prog[0], 0);
        send_byte(prog[1][7:0], 0);
        send_byte(prog[1][15:8], 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_writes", 64'(wr_a.size()), 64'd1);
        if (wr_a.size() > 0) begin
            check("abort_addr", 64'(wr_a[0]), 64'd0);
            check("abort_data", 64'(wr_d[0]), 64'(prog[0]));
        end
        check("abort_flags", 64'({cpu_run, busy, in_ready, error}), 64'd0);
        check("abort_words", 64'(words_loaded), 64'd0);
        run_load(32'd2, 32'h8C231824, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
